// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data memory load/store unit.
// Holds the RISC-V load/store funct3 encodings, the 2-bit fault codes,
// the controller state type and a helper that decides funct3 legality.
package riscv_mem_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_FUNCT3   = 2'b11;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Stores only have byte/half/word forms; loads add the unsigned variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~is_store;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_memory_lsu_if.sv
// Request/response bus between the core's EX/MEM stage and the data memory.
// Request:  REQ_VALID, REQ_READY, MemWrite, Funct3, Address, WD
// Response: RSP_VALID, RD, ERR, ERR_CODE (valid for exactly one cycle)
// master = core side, slave = memory side.
interface data_memory_lsu_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Address;
  logic [31:0] WD;
  logic        RSP_VALID;
  logic [31:0] RD;
  logic        ERR;
  logic [1:0]  ERR_CODE;

  modport master (
    output REQ_VALID, MemWrite, Funct3, Address, WD,
    input  REQ_READY, RSP_VALID, RD, ERR, ERR_CODE
  );

  modport slave (
    input  REQ_VALID, MemWrite, Funct3, Address, WD,
    output REQ_READY, RSP_VALID, RD, ERR, ERR_CODE
  );
endinterface

// File: rtl/data_memory_lsu_lane_align.sv
// Byte-lane steering for the data memory (purely combinational).
// Store side: i_wd, i_st_funct3, i_st_lane -> o_be (byte enables), o_wdata
//             (store data replicated onto every lane it may land in).
// Load side:  i_rword, i_ld_funct3, i_ld_lane -> o_rd (selected lane(s),
//             sign- or zero-extended to 32 bits).
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] i_wd,
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_lane,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_rword,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_lane,
  output logic [31:0] o_rd
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store lane enables and replicated write data.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wd;
    case (i_st_funct3)
      FUNCT3_SB: begin
        o_be    = 4'b0001 << i_st_lane;
        o_wdata = {4{i_wd[7:0]}};
      end
      FUNCT3_SH: begin
        o_be    = i_st_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wd[15:0]}};
      end
      FUNCT3_SW: begin
        o_be    = 4'b1111;
        o_wdata = i_wd;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = i_wd;
      end
    endcase
  end

  // Load lane selection and extension.
  always_comb begin
    w_byte = 8'h00;
    case (i_ld_lane)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      2'd3:    w_byte = i_rword[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_ld_lane[1] ? i_rword[31:16] : i_rword[15:0];
    case (i_ld_funct3)
      FUNCT3_LB:  o_rd = {{24{w_byte[7]}}, w_byte};
      FUNCT3_LH:  o_rd = {{16{w_half[15]}}, w_half};
      FUNCT3_LW:  o_rd = i_rword;
      FUNCT3_LBU: o_rd = {24'h000000, w_byte};
      FUNCT3_LHU: o_rd = {16'h0000, w_half};
      default:    o_rd = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Data memory with a valid/ready request port and a 1-cycle registered
// response. After reset it sweeps every word to zero (REQ_READY low), then
// accepts one load or store per cycle. Faulting accesses (illegal funct3,
// out of range, misaligned) never touch the array and return RD=0.
// Ports: CLK, RST_N (async, active-low), bus (data_memory_lsu_if.slave).
module data_memory_lsu
  import riscv_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_C000
) (
  input  logic             CLK,
  input  logic             RST_N,
  data_memory_lsu_if.slave bus
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  logic [31:0]   r_mem [DEPTH_WORDS];
  state_e        r_state;
  logic [AW-1:0] r_clr_idx;
  logic          r_ready;
  logic          r_rsp_valid;
  logic          r_err;
  logic [1:0]    r_err_code;
  logic          r_ld_ok;
  logic [2:0]    r_ld_f3;
  logic [1:0]    r_ld_lane;
  logic [31:0]   r_rword;

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_misalign;
  logic [1:0]    w_code;
  logic          w_fault;
  logic          w_accept;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_ld_rd;

  // Unsigned wrap makes addresses below BASE_ADDR land far above SPAN_BYTES,
  // so a single compare covers both ends of the window.
  assign w_off    = bus.Address - BASE_ADDR;
  assign w_idx    = w_off[AW+1:2];
  assign w_accept = bus.REQ_VALID & r_ready;
  assign w_fault  = (w_code != ERR_NONE);

  // Fault classification in priority order: funct3, range, alignment.
  always_comb begin
    case (bus.Funct3[1:0])
      2'b01:   w_misalign = bus.Address[0];
      2'b10:   w_misalign = |bus.Address[1:0];
      default: w_misalign = 1'b0;
    endcase
    if (!f3_legal(bus.MemWrite, bus.Funct3)) begin
      w_code = ERR_FUNCT3;
    end else if (w_off >= SPAN_BYTES) begin
      w_code = ERR_RANGE;
    end else if (w_misalign) begin
      w_code = ERR_MISALIGN;
    end else begin
      w_code = ERR_NONE;
    end
  end

  dmem_lane_align u_align (
    .i_wd        (bus.WD),
    .i_st_funct3 (bus.Funct3),
    .i_st_lane   (bus.Address[1:0]),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .i_rword     (r_rword),
    .i_ld_funct3 (r_ld_f3),
    .i_ld_lane   (r_ld_lane),
    .o_rd        (w_ld_rd)
  );

  // Storage array: clear sweep writes, lane-masked stores, and the load read.
  always_ff @(posedge CLK) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= 32'h0000_0000;
    end else if (w_accept && !w_fault) begin
      if (bus.MemWrite) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) begin
            r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
          end
        end
      end else begin
        r_rword <= r_mem[w_idx];
      end
    end
  end

  // Controller: clear sweep, then run; registers the response fields.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_CLEAR;
      r_clr_idx   <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_ld_ok     <= 1'b0;
      r_ld_f3     <= 3'b000;
      r_ld_lane   <= 2'b00;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_rsp_valid <= 1'b0;
          r_clr_idx   <= r_clr_idx + 1'b1;
          if (r_clr_idx == LAST_IDX) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_rsp_valid <= w_accept;
          if (w_accept) begin
            r_err      <= w_fault;
            r_err_code <= w_code;
            r_ld_ok    <= ~bus.MemWrite & ~w_fault;
            r_ld_f3    <= bus.Funct3;
            r_ld_lane  <= bus.Address[1:0];
          end
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_clr_idx   <= '0;
          r_ready     <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.REQ_READY = r_ready;
  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.ERR       = r_err;
  assign bus.ERR_CODE  = r_err_code;
  // Stores and faults leave r_ld_ok low, so RD reads back as zero.
  assign bus.RD        = r_ld_ok ? w_ld_rd : 32'h0000_0000;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: directed scenarios plus random
// traffic checked against a byte-addressed reference model.
module tb_data_memory_lsu;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_C000;
  localparam int          NBYTES = DEPTH * 4;

  logic CLK;
  logic RST_N;
  data_memory_lsu_if bus();

  data_memory_lsu #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mem_b [NBYTES];
  logic [31:0] last_rd;
  logic        last_err;
  logic [1:0]  last_code;

  logic [2:0] ld_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] st_ops [3] = '{3'd0, 3'd1, 3'd2};

  task automatic model_reset();
    for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;
  endtask

  // Reference: byte-addressed memory, little-endian, RISC-V access rules.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output logic err, output logic [1:0] code);
    bit     legal;
    longint off;
    int     size;
    longint v;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    off   = longint'(addr) - longint'(BASE);
    size  = 1 << f3[1:0];
    rd    = 32'h0;
    if (!legal) code = 2'd3;
    else if (off < 0 || off >= NBYTES) code = 2'd2;
    else if ((addr % size) != 0) code = 2'd1;
    else code = 2'd0;
    err = (code != 2'd0);
    if (!err) begin
      if (we) begin
        for (int k = 0; k < size; k++) mem_b[int'(off) + k] = 8'((wd >> (8 * k)) & 32'hFF);
      end else begin
        v = 0;
        for (int k = 0; k < size; k++) v = v + (longint'(mem_b[int'(off) + k]) << (8 * k));
        if (!f3[2] && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
        rd = 32'(v);
      end
    end
  endtask

  // Drive one cycle of request inputs at a negedge and wait for the next negedge.
  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.REQ_VALID = v;
    bus.MemWrite  = we;
    bus.Funct3    = f3;
    bus.Address   = a;
    bus.WD        = wd;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    int cnt;
    bit rsp_seen;
    @(negedge CLK);
    n_checks++;
    if ({bus.REQ_READY, bus.RSP_VALID, bus.ERR, bus.ERR_CODE, bus.RD} !== 36'h0)
      $display("FAIL reset_outputs: got rdy=%b v=%b err=%b code=%b rd=%h want all 0",
               bus.REQ_READY, bus.RSP_VALID, bus.ERR, bus.ERR_CODE, bus.RD);
    else n_pass++;
    bus.REQ_VALID = 1'b1; bus.MemWrite = 1'b0; bus.Funct3 = 3'd2;
    bus.Address = BASE; bus.WD = 32'h0;
    RST_N = 1'b1;
    cnt = 0; rsp_seen = 0;
    while (bus.REQ_READY !== 1'b1 && cnt < 5000) begin
      @(negedge CLK);
      cnt++;
      if (bus.RSP_VALID === 1'b1) rsp_seen = 1;
    end
    n_checks++;
    if (cnt != DEPTH || rsp_seen)
      $display("FAIL clear_len: got %0d cycles rsp_seen=%0d want %0d cycles rsp_seen=0", cnt, rsp_seen, DEPTH);
    else n_pass++;
    model_reset();
    @(negedge CLK);
    n_checks++;
    if ({bus.RSP_VALID, bus.ERR, bus.RD} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL lw_first: got v=%b err=%b rd=%h want v=1 err=0 rd=0", bus.RSP_VALID, bus.ERR, bus.RD);
    else n_pass++;
    drive(1'b1, 1'b0, 3'd2, 32'h0000_FFFC, 32'h0);
    n_checks++;
    if ({bus.RSP_VALID, bus.ERR, bus.RD} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL lw_last: got v=%b err=%b rd=%h want v=1 err=0 rd=0", bus.RSP_VALID, bus.ERR, bus.RD);
    else n_pass++;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    n_checks++;
    if (bus.RSP_VALID !== 1'b0)
      $display("FAIL idle_no_rsp: got v=%b want v=0", bus.RSP_VALID);
    else n_pass++;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic e; logic [1:0] c;
    model_access(1'b1, 3'd2, 32'h0000_FFD0, 32'h8765_4321, rd, e, c);
    drive(1'b1, 1'b1, 3'd2, 32'h0000_FFD0, 32'h8765_4321);
    n_checks++;
    if ({bus.RSP_VALID, bus.ERR, bus.RD} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL sw_rsp: got v=%b err=%b rd=%h want v=1 err=0 rd=0", bus.RSP_VALID, bus.ERR, bus.RD);
    else n_pass++;
    model_access(1'b0, 3'd2, 32'h0000_FFD0, 32'h0, rd, e, c);
    drive(1'b1, 1'b0, 3'd2, 32'h0000_FFD0, 32'h0);
    n_checks++;
    if ({bus.RSP_VALID, bus.ERR, bus.RD} !== {1'b1, 1'b0, 32'h8765_4321})
      $display("FAIL lw_after_sw: got v=%b err=%b rd=%h want v=1 err=0 rd=87654321", bus.RSP_VALID, bus.ERR, bus.RD);
    else n_pass++;
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic e; logic [1:0] c;
    model_access(1'b1, 3'd0, 32'h0000_FFD1, 32'h0000_00A5, rd, e, c);
    drive(1'b1, 1'b1, 3'd0, 32'h0000_FFD1, 32'h0000_00A5);
    model_access(1'b0, 3'd0, 32'h0000_FFD1, 32'h0, rd, e, c);
    drive(1'b1, 1'b0, 3'd0, 32'h0000_FFD1, 32'h0);
    n_checks++;
    if ({bus.RSP_VALID, bus.RD} !== {1'b1, 32'hFFFF_FFA5})
      $display("FAIL lb: got v=%b rd=%h want v=1 rd=ffffffa5", bus.RSP_VALID, bus.RD);
    else n_pass++;
    drive(1'b1, 1'b0, 3'd4, 32'h0000_FFD1, 32'h0);
    n_checks++;
    if ({bus.RSP_VALID, bus.RD} !== {1'b1, 32'h0000_00A5})
      $display("FAIL lbu: got v=%b rd=%h want v=1 rd=000000a5", bus.RSP_VALID, bus.RD);
    else n_pass++;
    drive(1'b1, 1'b0, 3'd2, 32'h0000_FFD0, 32'h0);
    n_checks++;
    if ({bus.RSP_VALID, bus.RD} !== {1'b1, 32'h8765_A521})
      $display("FAIL lw_merge: got v=%b rd=%h want v=1 rd=8765a521", bus.RSP_VALID, bus.RD);
    else n_pass++;
    drive(1'b1, 1'b0, 3'd1, 32'h0000_FFD2, 32'h0);
    n_checks++;
    if ({bus.RSP_VALID, bus.RD} !== {1'b1, 32'hFFFF_8765})
      $display("FAIL lh_hi: got v=%b rd=%h want v=1 rd=ffff8765", bus.RSP_VALID, bus.RD);
    else n_pass++;
  endtask

  task automatic test_faults();
    drive(1'b1, 1'b1, 3'd1, 32'h0000_FFD3, 32'h0000_1234);
    n_checks++;
    if ({bus.RSP_VALID, bus.ERR, bus.ERR_CODE, bus.RD} !== {1'b1, 1'b1, 2'b01, 32'h0})
      $display("FAIL sh_misalign: got v=%b err=%b code=%b rd=%h want 1 1 01 0", bus.RSP_VALID, bus.ERR, bus.ERR_CODE, bus.RD);
    else n_pass++;
    drive(1'b1, 1'b0, 3'd2, 32'h0000_FFD0, 32'h0);
    n_checks++;
    if ({bus.ERR, bus.RD} !== {1'b0, 32'h8765_A521})
      $display("FAIL unchanged: got err=%b rd=%h want err=0 rd=8765a521", bus.ERR, bus.RD);
    else n_pass++;
    drive(1'b1, 1'b0, 3'd2, 32'h0001_0000, 32'h0);
    n_checks++;
    if ({bus.ERR, bus.ERR_CODE, bus.RD} !== {1'b1, 2'b10, 32'h0})
      $display("FAIL range_hi: got err=%b code=%b rd=%h want 1 10 0", bus.ERR, bus.ERR_CODE, bus.RD);
    else n_pass++;
    drive(1'b1, 1'b0, 3'd2, 32'h0000_BFFC, 32'h0);
    n_checks++;
    if ({bus.ERR, bus.ERR_CODE} !== {1'b1, 2'b10})
      $display("FAIL range_lo: got err=%b code=%b want 1 10", bus.ERR, bus.ERR_CODE);
    else n_pass++;
    drive(1'b1, 1'b0, 3'd3, 32'h0000_FFD0, 32'h0);
    n_checks++;
    if ({bus.ERR, bus.ERR_CODE, bus.RD} !== {1'b1, 2'b11, 32'h0})
      $display("FAIL f3_011: got err=%b code=%b rd=%h want 1 11 0", bus.ERR, bus.ERR_CODE, bus.RD);
    else n_pass++;
    drive(1'b1, 1'b1, 3'd4, 32'h0000_FFD0, 32'hFFFF_FFFF);
    n_checks++;
    if ({bus.ERR, bus.ERR_CODE} !== {1'b1, 2'b11})
      $display("FAIL st_f3_100: got err=%b code=%b want 1 11", bus.ERR, bus.ERR_CODE);
    else n_pass++;
    drive(1'b1, 1'b0, 3'd2, 32'h0000_FFD0, 32'h0);
    n_checks++;
    if ({bus.ERR, bus.RD} !== {1'b0, 32'h8765_A521})
      $display("FAIL unchanged2: got err=%b rd=%h want err=0 rd=8765a521", bus.ERR, bus.RD);
    else n_pass++;
    last_rd = 32'h8765_A521; last_err = 1'b0; last_code = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; logic [1:0] c;
    for (int i = 0; i < 3; i++) begin
      model_access(1'b1, 3'd2, 32'h0000_FF00 + 32'(4 * i), 32'(i + 1), rd, e, c);
      drive(1'b1, 1'b1, 3'd2, 32'h0000_FF00 + 32'(4 * i), 32'(i + 1));
      n_checks++;
      if ({bus.RSP_VALID, bus.ERR} !== {1'b1, 1'b0})
        $display("FAIL b2b_sw%0d: got v=%b err=%b want v=1 err=0", i, bus.RSP_VALID, bus.ERR);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'd2, 32'h0000_FF00 + 32'(4 * i), 32'h0);
      n_checks++;
      if ({bus.RSP_VALID, bus.RD} !== {1'b1, 32'(i + 1)})
        $display("FAIL b2b_lw%0d: got v=%b rd=%h want v=1 rd=%h", i, bus.RSP_VALID, bus.RD, 32'(i + 1));
      else n_pass++;
    end
    last_rd = 32'd3; last_err = 1'b0; last_code = 2'b00;
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd; logic e, we; logic [1:0] c; logic [2:0] f3;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        n_checks++;
        if ({bus.RSP_VALID, bus.ERR, bus.ERR_CODE, bus.RD} !== {1'b0, last_err, last_code, last_rd})
          $display("FAIL rnd_hold%0d: got v=%b err=%b code=%b rd=%h want v=0 err=%b code=%b rd=%h",
                   n, bus.RSP_VALID, bus.ERR, bus.ERR_CODE, bus.RD, last_err, last_code, last_rd);
        else n_pass++;
      end else begin
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
        else if (we) f3 = st_ops[$urandom_range(0, 2)];
        else f3 = ld_ops[$urandom_range(0, 4)];
        addr = BASE + 32'h3F00 + 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) addr = addr & 32'hFFFF_FFFC;
        if ($urandom_range(0, 15) == 0) addr = BASE + 32'h4000 + 32'($urandom_range(0, 8));
        else if ($urandom_range(0, 15) == 0) addr = BASE - 32'($urandom_range(1, 8));
        wd = $urandom;
        model_access(we, f3, addr, wd, rd, e, c);
        drive(1'b1, we, f3, addr, wd);
        n_checks++;
        if ({bus.RSP_VALID, bus.ERR, bus.ERR_CODE, bus.RD} !== {1'b1, e, c, rd})
          $display("FAIL rnd%0d we=%b f3=%0d a=%h: got v=%b err=%b code=%b rd=%h want v=1 err=%b code=%b rd=%h",
                   n, we, f3, addr, bus.RSP_VALID, bus.ERR, bus.ERR_CODE, bus.RD, e, c, rd);
        else n_pass++;
        last_rd = rd; last_err = e; last_code = c;
      end
    end
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    int cnt;
    bit rsp_seen;
    bus.REQ_VALID = 1'b1; bus.MemWrite = 1'b1; bus.Funct3 = 3'd2;
    bus.Address = 32'h0000_FFD0; bus.WD = 32'hDEAD_BEEF;
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if ({bus.REQ_READY, bus.RSP_VALID, bus.ERR, bus.ERR_CODE, bus.RD} !== 36'h0)
      $display("FAIL rst_run: got rdy=%b v=%b err=%b code=%b rd=%h want all 0",
               bus.REQ_READY, bus.RSP_VALID, bus.ERR, bus.ERR_CODE, bus.RD);
    else n_pass++;
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    bus.MemWrite = 1'b0; bus.Funct3 = 3'd2;
    rsp_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (bus.RSP_VALID === 1'b1 || bus.REQ_READY === 1'b1) rsp_seen = 1;
    end
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if ({bus.REQ_READY, bus.RSP_VALID, rsp_seen} !== 3'b000)
      $display("FAIL rst_clear: got rdy=%b v=%b activity=%0d want 0 0 0", bus.REQ_READY, bus.RSP_VALID, rsp_seen);
    else n_pass++;
    @(negedge CLK);
    RST_N = 1'b1;
    cnt = 0;
    while (bus.REQ_READY !== 1'b1 && cnt < 5000) begin
      @(negedge CLK);
      cnt++;
    end
    n_checks++;
    if (cnt != DEPTH)
      $display("FAIL reclear_len: got %0d cycles want %0d", cnt, DEPTH);
    else n_pass++;
    model_reset();
    @(negedge CLK);
    n_checks++;
    if ({bus.RSP_VALID, bus.ERR, bus.RD} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL lw_after_reclear: got v=%b err=%b rd=%h want v=1 err=0 rd=0", bus.RSP_VALID, bus.ERR, bus.RD);
    else n_pass++;
    drive(1'b1, 1'b0, 3'd2, 32'h0000_FF04, 32'h0);
    n_checks++;
    if ({bus.RSP_VALID, bus.RD} !== {1'b1, 32'h0})
      $display("FAIL lw_ff04_cleared: got v=%b rd=%h want v=1 rd=0", bus.RSP_VALID, bus.RD);
    else n_pass++;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  initial begin
    RST_N = 1'b0;
    bus.REQ_VALID = 1'b0; bus.MemWrite = 1'b0; bus.Funct3 = 3'd0;
    bus.Address = 32'h0; bus.WD = 32'h0;
    last_rd = 32'h0; last_err = 1'b0; last_code = 2'b00;
    model_reset();
    test_reset();
    test_store_load();
    test_byte_half();
    test_faults();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
